mode_counter: RTL and testbench
===============================

Name: mode_counter

Overview:
- Parametrised successor to the fixed 32-bit +1 counter.
- Registered up/down/load counter: a 4-way mode select picks the next value from hold, add-step, subtract-step or load.
- Programmable terminal limit, with wrap or saturate policy.
- Registered overflow pulse and sticky flag.
- Serves as a general event/address/timer counter in the datapath.

Parameters:
- WIDTH, 32, counter and operand width in bits (>=2)
- SATURATE, 0, 0 = wrap at boundaries, 1 = clamp at boundaries
- RESET_VAL, 0, value loaded into count on reset (must be <= limit in use)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; 0 forces hold
- mode  in  2  0 = hold, 1 = increment by step, 2 = decrement by step, 3 = load
- step  in  WIDTH  increment/decrement amount (unsigned)
- load_val  in  WIDTH  value for mode 3
- limit  in  WIDTH  inclusive upper bound of count range [0, limit]
- clr_sticky  in  1  synchronous clear of ovf_sticky
- count  out  WIDTH  registered counter value
- ovf  out  1  registered one-cycle pulse on a boundary event
- ovf_sticky  out  1  registered sticky boundary flag
- zero  out  1  high when count == 0 (decoded from register, no input path)

Behaviour:
- Reset (async, active-high, immediate on assertion):
  - count = RESET_VAL, ovf = 0, ovf_sticky = 0.
  - Reset mid-operation discards the in-flight update; first update happens on the first rising edge after deassertion.
- Latency: 1 cycle. Next-state is computed combinationally and registered on the rising edge of clk.
- en = 0 or mode = 0: count holds, ovf = 0, ovf_sticky holds (subject to clr_sticky).
- All arithmetic is unsigned, computed at WIDTH+1 bits so the carry is never lost.
- Increment (mode 1):
  - sum = count + step (WIDTH+1 bits).
  - If sum <= limit: next = sum[WIDTH-1:0], no event.
  - If sum > limit: event; next = 0 if SATURATE = 0, next = limit if SATURATE = 1.
- Decrement (mode 2):
  - If count >= step: next = count - step, no event.
  - Else: event; next = limit if SATURATE = 0, next = 0 if SATURATE = 1.
- Load (mode 3):
  - If load_val <= limit: next = load_val, no event.
  - Else: next = limit, event (both policies).
- step = 0 in mode 1 or 2: count holds; an event fires only if count > limit (increment) — a legal, defined case.
- limit lowered below the current count at runtime:
  - Next increment takes the event path.
  - Decrement proceeds normally.
  - count is never corrected otherwise.
- limit = 0: increment with step >= 1 always fires an event; wrap/saturate both yield 0.
- limit = all-ones with SATURATE = 0: reproduces the plain modulo-2^WIDTH counter of the previous generation.
- ovf: registered = event for the current cycle; high for exactly one cycle per event, including back-to-back events on consecutive cycles.
- ovf_sticky: next = (ovf_sticky & ~clr_sticky) | event. A simultaneous event and clr_sticky leaves it set.
- zero is decoded from the count register only.
- No combinational path from any input to any output.

Test Plan:
All scenarios use WIDTH = 8.
- Reset mid-count:
  - Stimulus: RESET_VAL = 5, counting up with step 1; assert reset asynchronously between edges.
  - Required: count = 5, ovf = 0, ovf_sticky = 0 immediately, before the next clk edge; count resumes 5 → 6 after deassertion.
- Wrap up:
  - Stimulus: SATURATE = 0, limit = 9, step = 3, en = 1, mode = 1 from count 0.
  - Required: count sequence 0, 3, 6, 9, 0, 3; ovf high only in the cycle count shows 0 after 9; ovf_sticky = 1 thereafter.
- Saturate down and load clamp:
  - Stimulus: SATURATE = 1, limit = 200, load_val = 250, mode = 3; then mode = 2 with step = 150 for 2 cycles.
  - Required: count = 200 with ovf pulse; then 50; then 0 with ovf pulse; zero = 1.
- Full-range wrap:
  - Stimulus: SATURATE = 0, limit = 255, count = 254, step = 2, mode = 1.
  - Required: count = 0, ovf = 1; the 9-bit carry is not lost.
- Sticky clear race:
  - Stimulus: ovf_sticky = 1; cycle A: clr_sticky = 1 with no event; cycle B: clr_sticky = 1 with a simultaneous decrement underflow.
  - Required: after A, ovf_sticky = 0; after B, ovf_sticky = 1 and ovf = 1.
- Enable/hold:
  - Stimulus: count = 7; en = 0 with mode = 1; then en = 1 with mode = 0, for 3 cycles each.
  - Required: count stays 7, ovf stays 0 throughout.

Source files
------------

// File: rtl/mode_counter_if.sv
// mode_counter_if: control inputs and status outputs of the mode counter
interface mode_counter_if #(parameter int WIDTH = 32);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
   logic             clr_sticky;
   logic [WIDTH-1:0] count;
   logic             ovf;
   logic             ovf_sticky;
   logic             zero;
   modport master (output en, mode, step, load_val, limit, clr_sticky, input count, ovf, ovf_sticky, zero);
   modport slave (input en, mode, step, load_val, limit, clr_sticky, output count, ovf, ovf_sticky, zero);
endinterface

// File: rtl/mode_counter.sv
// mode_counter: hold/up/down/load counter with programmable limit, wrap or saturate, overflow pulse and sticky flag
module mode_counter #(
   parameter int WIDTH = 32,
   parameter int SATURATE = 0,
   parameter int RESET_VAL = 0
) (
   input logic clk,
   input logic reset,
   mode_counter_if.slave bus
);
   logic [WIDTH-1:0] count_q, count_d, inc_nx, dec_nx, ld_nx;
   logic             ovf_q, ovf_d, sticky_q, sticky_d;
   logic [WIDTH:0]   sum;
   logic [1:0]       act;
   logic             inc_ev, dec_ev, ld_ev, ev;
   always_comb begin
      act      = bus.en ? bus.mode : 2'd0;
      sum      = {1'b0, count_q} + {1'b0, bus.step};
      inc_ev   = sum > {1'b0, bus.limit};
      dec_ev   = count_q < bus.step;
      ld_ev    = bus.load_val > bus.limit;
      inc_nx   = inc_ev ? (SATURATE != 0 ? bus.limit : '0) : sum[WIDTH-1:0];
      dec_nx   = dec_ev ? (SATURATE != 0 ? '0 : bus.limit) : count_q - bus.step;
      ld_nx    = ld_ev ? bus.limit : bus.load_val;
      ev       = act == 2'd1 ? inc_ev : act == 2'd2 ? dec_ev : act == 2'd3 ? ld_ev : 1'b0;
      count_d  = act == 2'd1 ? inc_nx : act == 2'd2 ? dec_nx : act == 2'd3 ? ld_nx : count_q;
      ovf_d    = ev;
      sticky_d = (sticky_q & ~bus.clr_sticky) | ev;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= WIDTH'(RESET_VAL);
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
      end
   end
   assign bus.count      = count_q;
   assign bus.ovf        = ovf_q;
   assign bus.ovf_sticky = sticky_q;
   assign bus.zero       = count_q == '0;
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: wrap and saturate counters driven in lockstep against a rule-level model
module tb_mode_counter;
   logic clk = 0, reset = 1;
   logic en = 0, clr_sticky = 0;
   logic [1:0] mode = 0;
   logic [7:0] step = 0, load_val = 0, limit = 8'd255;
   int total = 0, bad = 0;
   int mc[2];
   bit mo[2], ms[2];
   logic [7:0] cnt_o[2];
   logic ovf_o[2], stk_o[2], zr_o[2];
   mode_counter_if #(.WIDTH(8)) iw ();
   mode_counter_if #(.WIDTH(8)) is ();
   assign iw.en = en;
   assign iw.mode = mode;
   assign iw.step = step;
   assign iw.load_val = load_val;
   assign iw.limit = limit;
   assign iw.clr_sticky = clr_sticky;
   assign is.en = en;
   assign is.mode = mode;
   assign is.step = step;
   assign is.load_val = load_val;
   assign is.limit = limit;
   assign is.clr_sticky = clr_sticky;
   assign cnt_o[0] = iw.count;
   assign ovf_o[0] = iw.ovf;
   assign stk_o[0] = iw.ovf_sticky;
   assign zr_o[0] = iw.zero;
   assign cnt_o[1] = is.count;
   assign ovf_o[1] = is.ovf;
   assign stk_o[1] = is.ovf_sticky;
   assign zr_o[1] = is.zero;
   mode_counter #(.WIDTH(8), .SATURATE(0), .RESET_VAL(5)) dut_w (.clk(clk), .reset(reset), .bus(iw));
   mode_counter #(.WIDTH(8), .SATURATE(1), .RESET_VAL(5)) dut_s (.clk(clk), .reset(reset), .bus(is));
   always #5 clk = ~clk;
   function automatic void nxt(input int sat, input int c, output int n, output bit e);
      int m, st, lim, lv;
      m = en ? int'(mode) : 0;
      st = int'(step);
      lim = int'(limit);
      lv = int'(load_val);
      n = c;
      e = 0;
      if (m == 1) begin
         if (c + st > lim) begin e = 1; n = sat ? lim : 0; end
         else n = c + st;
      end else if (m == 2) begin
         if (c >= st) n = c - st;
         else begin e = 1; n = sat ? 0 : lim; end
      end else if (m == 3) begin
         if (lv > lim) begin e = 1; n = lim; end
         else n = lv;
      end
   endfunction
   task automatic tick();
      int n[2];
      bit e[2];
      for (int k = 0; k < 2; k++) nxt(k, mc[k], n[k], e[k]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         ms[k] = (ms[k] && !clr_sticky) || e[k];
         mc[k] = n[k];
         mo[k] = e[k];
      end
   endtask
   task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] s, input logic [7:0] lv, input logic [7:0] lim, input logic c);
      en = e; mode = m; step = s; load_val = lv; limit = lim; clr_sticky = c;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin mc[k] = 5; mo[k] = 0; ms[k] = 0; end
      for (int k = 0; k < 2; k++) begin
         total++;
         if (cnt_o[k] !== 8'd5 || ovf_o[k] !== 1'b0 || stk_o[k] !== 1'b0) begin
            bad++; $display("FAIL reset_init k=%0d count=%0d ovf=%b sticky=%b want 5/0/0", k, cnt_o[k], ovf_o[k], stk_o[k]);
         end
      end
      reset = 0;
      drive(1, 2'd1, 8'd1, 8'd0, 8'd255, 0);
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (cnt_o[k] !== 8'd8) begin bad++; $display("FAIL reset_pre_count k=%0d got=%0d want=8", k, cnt_o[k]); end
      end
      #2 reset = 1;
      #1;
      for (int k = 0; k < 2; k++) begin mc[k] = 5; mo[k] = 0; ms[k] = 0; end
      for (int k = 0; k < 2; k++) begin
         total++;
         if (cnt_o[k] !== 8'd5 || ovf_o[k] !== 1'b0 || stk_o[k] !== 1'b0) begin
            bad++; $display("FAIL reset_async k=%0d count=%0d ovf=%b sticky=%b want 5/0/0", k, cnt_o[k], ovf_o[k], stk_o[k]);
         end
      end
      #2 reset = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (cnt_o[k] !== 8'd6) begin bad++; $display("FAIL reset_resume k=%0d got=%0d want=6", k, cnt_o[k]); end
      end
   endtask
   task automatic test_wrap_up();
      int seq[6] = '{0, 3, 6, 9, 0, 3};
      drive(1, 2'd3, 8'd3, 8'd0, 8'd9, 0);
      tick();
      mode = 2'd1;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (cnt_o[0] !== 8'(seq[i]) || ovf_o[0] !== (i == 4) || stk_o[0] !== (i >= 4)) begin
            bad++; $display("FAIL wrap_up i=%0d count=%0d ovf=%b sticky=%b want %0d/%b/%b", i, cnt_o[0], ovf_o[0], stk_o[0], seq[i], i == 4, i >= 4);
         end
         if (i < 5) tick();
      end
   endtask
   task automatic test_sat_down_load();
      int ec[3] = '{200, 50, 0};
      bit eo[3] = '{1, 0, 1};
      drive(1, 2'd3, 8'd150, 8'd250, 8'd200, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         mode = 2'd2;
         total++;
         if (cnt_o[1] !== 8'(ec[i]) || ovf_o[1] !== eo[i] || zr_o[1] !== (ec[i] == 0)) begin
            bad++; $display("FAIL sat_down i=%0d count=%0d ovf=%b zero=%b want %0d/%b/%b", i, cnt_o[1], ovf_o[1], zr_o[1], ec[i], eo[i], ec[i] == 0);
         end
      end
   endtask
   task automatic test_full_wrap();
      drive(1, 2'd3, 8'd2, 8'd254, 8'd255, 0);
      tick();
      mode = 2'd1;
      tick();
      total++;
      if (cnt_o[0] !== 8'd0 || ovf_o[0] !== 1'b1) begin
         bad++; $display("FAIL full_wrap count=%0d ovf=%b want 0/1", cnt_o[0], ovf_o[0]);
      end
      total++;
      if (cnt_o[1] !== 8'd255 || ovf_o[1] !== 1'b1) begin
         bad++; $display("FAIL full_sat count=%0d ovf=%b want 255/1", cnt_o[1], ovf_o[1]);
      end
   endtask
   task automatic test_sticky_race();
      drive(1, 2'd0, 8'd1, 8'd0, 8'd255, 1);
      tick();
      total++;
      if (stk_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
         bad++; $display("FAIL sticky_clear sticky=%b ovf=%b want 0/0", stk_o[0], ovf_o[0]);
      end
      mode = 2'd2;
      tick();
      total++;
      if (stk_o[0] !== 1'b1 || ovf_o[0] !== 1'b1 || cnt_o[0] !== 8'd255) begin
         bad++; $display("FAIL sticky_race sticky=%b ovf=%b count=%0d want 1/1/255", stk_o[0], ovf_o[0], cnt_o[0]);
      end
      clr_sticky = 0;
   endtask
   task automatic test_enable_hold();
      drive(1, 2'd3, 8'd1, 8'd7, 8'd255, 0);
      tick();
      for (int i = 0; i < 6; i++) begin
         en = i >= 3;
         mode = i >= 3 ? 2'd0 : 2'd1;
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt_o[k] !== 8'd7 || ovf_o[k] !== 1'b0) begin
               bad++; $display("FAIL hold i=%0d k=%0d count=%0d ovf=%b want 7/0", i, k, cnt_o[k], ovf_o[k]);
            end
         end
      end
   endtask
   task automatic test_back_to_back();
      drive(1, 2'd1, 8'd1, 8'd0, 8'd0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt_o[k] !== 8'd0 || ovf_o[k] !== 1'b1) begin
               bad++; $display("FAIL back_to_back i=%0d k=%0d count=%0d ovf=%b want 0/1", i, k, cnt_o[k], ovf_o[k]);
            end
         end
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 7) != 0, 2'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom),
               8'($urandom), 8'($urandom_range(0, 1) == 0 ? $urandom_range(0, 20) : $urandom), $urandom_range(0, 5) == 0);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt_o[k] !== 8'(mc[k]) || ovf_o[k] !== mo[k] || stk_o[k] !== ms[k] || zr_o[k] !== (mc[k] == 0)) begin
               bad++; $display("FAIL random i=%0d k=%0d count=%0d ovf=%b sticky=%b zero=%b want %0d/%b/%b/%b",
                               i, k, cnt_o[k], ovf_o[k], stk_o[k], zr_o[k], mc[k], mo[k], ms[k], mc[k] == 0);
            end
         end
      end
   endtask
   initial begin
      test_reset();
      test_wrap_up();
      test_sat_down_load();
      test_full_wrap();
      test_sticky_race();
      test_enable_hold();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
